// File: rtl/simpleadder_requester.sv
// Command FIFO plus IDLE/ISSUE/WAIT/RESP sequencer that drives an external adder and returns its result.
// Optional result checking is enabled by defining SIMPLEADDER_REQ_CHECK_EN.
module simpleadder_requester #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic              sig_clock,
    input  logic              sig_rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [1:0]        cmd_op,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W:0]   rsp_data,
    output logic [1:0]        rsp_status,
    output logic              sig_en_i,
    output logic [DATA_W-1:0] sig_ina,
    output logic [DATA_W-1:0] sig_inb,
    output logic [1:0]        operation,
    input  logic              sig_en_o,
    input  logic [DATA_W:0]   sig_out,
    output logic              busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam int ENT_W = 2 * DATA_W + 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t            state_q;
    logic [ENT_W-1:0]  fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic              push_s;
    logic              pop_s;
    logic [DATA_W-1:0] head_a_s;
    logic [DATA_W-1:0] head_b_s;
    logic [1:0]        head_op_s;
    logic [TMO_W-1:0]  tmo_q;
    logic              cmd_ready_q;
    logic              rsp_valid_q;
    logic              sig_en_i_q;
    logic              busy_q;
    logic [DATA_W:0]   rsp_data_q;
    logic [1:0]        rsp_status_q;
    logic [DATA_W-1:0] ina_q;
    logic [DATA_W-1:0] inb_q;
    logic [1:0]        op_q;

    // Handshake qualifiers, FIFO head decode and next occupancy
    always_comb begin
        push_s = cmd_valid && cmd_ready_q;
        pop_s  = (state_q == ST_IDLE) && (count_q != CNT_W'(0));
        {head_op_s, head_b_s, head_a_s} = fifo_q[rd_ptr_q];
        count_d = count_q;
        if (push_s && !pop_s) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_s && pop_s) begin
            count_d = count_q - CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Command FIFO storage and pointers; reset drops every queued entry
    always_ff @(posedge sig_clock or negedge sig_rst) begin
        if (!sig_rst) begin
            wr_ptr_q <= PTR_W'(0);
            rd_ptr_q <= PTR_W'(0);
            count_q  <= CNT_W'(0);
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= ENT_W'(0);
            end
        end else begin
            if (push_s) begin
                fifo_q[wr_ptr_q] <= {cmd_op, cmd_b, cmd_a};
                wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

`ifdef SIMPLEADDER_REQ_CHECK_EN
    logic [DATA_W-1:0] hold_a_q;
    logic [DATA_W-1:0] hold_b_q;
    logic [1:0]        hold_op_q;
    logic [DATA_W:0]   exp_s;

    function automatic logic [DATA_W:0] expected_result(input logic [DATA_W-1:0] a,
                                                        input logic [DATA_W-1:0] b,
                                                        input logic [1:0]        op);
        logic [DATA_W:0] r;
        case (op)
            2'b00:   r = {1'b0, a} + {1'b0, b};
            2'b01:   r = {1'b0, a} - {1'b0, b};
            default: r = {(DATA_W + 1){1'b0}};
        endcase
        return r;
    endfunction

    // Holding register for the command currently being serviced
    always_ff @(posedge sig_clock or negedge sig_rst) begin
        if (!sig_rst) begin
            hold_a_q  <= DATA_W'(0);
            hold_b_q  <= DATA_W'(0);
            hold_op_q <= 2'b00;
        end else if (pop_s) begin
            hold_a_q  <= head_a_s;
            hold_b_q  <= head_b_s;
            hold_op_q <= head_op_s;
        end
    end

    // Reference result the adder is expected to return
    always_comb begin
        exp_s = expected_result(hold_a_q, hold_b_q, hold_op_q);
    end
`endif

    // Sequencer with all handshake and adder-side outputs registered
    always_ff @(posedge sig_clock or negedge sig_rst) begin
        if (!sig_rst) begin
            state_q      <= ST_IDLE;
            tmo_q        <= TMO_W'(0);
            cmd_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= {(DATA_W + 1){1'b0}};
            rsp_status_q <= 2'b00;
            sig_en_i_q   <= 1'b0;
            ina_q        <= DATA_W'(0);
            inb_q        <= DATA_W'(0);
            op_q         <= 2'b00;
            busy_q       <= 1'b0;
        end else begin
            cmd_ready_q <= (count_d != CNT_W'(FIFO_DEPTH));
            case (state_q)
                ST_IDLE: begin
                    if (pop_s) begin
                        busy_q <= 1'b1;
                        if (!head_op_s[1]) begin
                            state_q    <= ST_ISSUE;
                            sig_en_i_q <= 1'b1;
                            ina_q      <= head_a_s;
                            inb_q      <= head_b_s;
                            op_q       <= head_op_s;
                        end else begin
                            // Unsupported opcodes are answered without touching the adder
                            state_q      <= ST_RESP;
                            rsp_valid_q  <= 1'b1;
                            rsp_data_q   <= {(DATA_W + 1){1'b0}};
                            rsp_status_q <= 2'b10;
                        end
                    end else begin
                        busy_q <= (count_d != CNT_W'(0));
                    end
                end
                ST_ISSUE: begin
                    state_q    <= ST_WAIT;
                    sig_en_i_q <= 1'b0;
                    tmo_q      <= TMO_W'(0);
                    busy_q     <= 1'b1;
                end
                ST_WAIT: begin
                    busy_q <= 1'b1;
                    if (sig_en_o) begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= sig_out;
`ifdef SIMPLEADDER_REQ_CHECK_EN
                        rsp_status_q <= (sig_out != exp_s) ? 2'b11 : 2'b00;
`else
                        rsp_status_q <= 2'b00;
`endif
                    end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                        state_q      <= ST_RESP;
                        rsp_valid_q  <= 1'b1;
                        rsp_data_q   <= {(DATA_W + 1){1'b0}};
                        rsp_status_q <= 2'b01;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_q     <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                        busy_q      <= (count_d != CNT_W'(0));
                    end else begin
                        busy_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    sig_en_i_q  <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    busy_q      <= (count_d != CNT_W'(0));
                end
            endcase
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_status = rsp_status_q;
    assign sig_en_i   = sig_en_i_q;
    assign sig_ina    = ina_q;
    assign sig_inb    = inb_q;
    assign operation  = op_q;
    assign busy       = busy_q;

endmodule

// File: doc/simpleadder_requester.md
SIMPLEADDER_REQUESTER -- requirements
Module: simpleadder_requester

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the operand width.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4 (power of 2), giving the command FIFO entries.
REQ-003 The block SHALL have parameter TIMEOUT, default 16, giving the maximum WAIT cycles before abort.
REQ-004 The block SHALL have port sig_clock  in  1  the single clock; all logic rising-edge.
REQ-005 The block SHALL have port sig_rst  in  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have ports cmd_valid in 1, cmd_ready out 1, cmd_a in DATA_W, cmd_b in DATA_W and cmd_op in 2, forming the command push handshake.
REQ-007 The block SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_data out DATA_W+1 and rsp_status out 2, forming the response handshake.
REQ-008 The block SHALL have ports sig_en_i out 1, sig_ina out DATA_W, sig_inb out DATA_W and operation out 2, which drive the adder.
REQ-009 The block SHALL have ports sig_en_o in 1 and sig_out in DATA_W+1, which carry the adder result.
REQ-010 The block SHALL have port busy out 1, high when the FSM is not in IDLE or the FIFO is non-empty.

Function
REQ-011 A command SHALL be pushed on a rising edge with cmd_valid=1 and cmd_ready=1, and cmd_ready SHALL be !fifo_full.
REQ-012 Push and pop SHALL be allowed in the same cycle; the FIFO count SHALL stay unchanged and order SHALL be preserved.
REQ-013 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP.
REQ-014 In IDLE with the FIFO non-empty, the FSM SHALL pop the head entry into a holding register.
REQ-015 After the IDLE pop, op 0 or 1 SHALL go to ISSUE, and op 2 or 3 SHALL go to RESP with status 2'b10, rsp_data 0 and no adder access.
REQ-016 ISSUE SHALL last exactly one cycle, with sig_en_i=1 and sig_ina, sig_inb and operation taken from the holding register, then go to WAIT.
REQ-017 Outside ISSUE, sig_en_i SHALL be 0, while sig_ina, sig_inb and operation hold their last values.
REQ-018 In WAIT, sig_en_o=1 on an edge SHALL capture sig_out into rsp_data, set status 2'b00 and go to RESP.
REQ-019 Nominal latency SHALL be one cycle: a result issued at edge N SHALL be captured at edge N+1.
REQ-020 A WAIT cycle counter SHALL start at 0 and abort when it reaches TIMEOUT-1 without sig_en_o, going to RESP with status 2'b01 and rsp_data 0.
REQ-021 If sig_en_o=1 on the timeout edge, capture SHALL win.
REQ-022 In RESP, rsp_valid=1 and rsp_data/rsp_status SHALL hold stable until rsp_ready=1.
REQ-023 On the RESP edge with rsp_ready=1, the FSM SHALL go to IDLE; the next command SHALL issue no earlier than 2 cycles later.
REQ-024 sig_en_o asserted outside WAIT SHALL be ignored.
REQ-025 Results SHALL be DATA_W+1 bits: an add SHALL carry into the MSB, and a subtract SHALL wrap modulo 2^(DATA_W+1).

Reset
REQ-026 While sig_rst=0, all of the following SHALL be forced asynchronously to 0: FSM=IDLE, FIFO pointers and count, timeout counter, cmd_ready, rsp_valid, rsp_data, rsp_status, sig_en_i, sig_ina, sig_inb, operation and busy.
REQ-027 Reset mid-operation (any state) SHALL discard all FIFO contents and any in-flight command without producing a response.
REQ-028 cmd_ready SHALL rise on the first edge after reset release.

Configuration
REQ-029 The macro SIMPLEADDER_REQ_CHECK_EN SHALL select the result-checking feature.
REQ-030 With SIMPLEADDER_REQ_CHECK_EN defined, the block SHALL compute the expected result from the holding register.
REQ-031 With SIMPLEADDER_REQ_CHECK_EN defined, a capture with sig_out differing from the expected result SHALL give status 2'b11, with rsp_data carrying the actual sig_out.
REQ-032 Without SIMPLEADDER_REQ_CHECK_EN, no checker logic SHALL exist and status 2'b11 SHALL never be produced.

Verification
REQ-033 The bench SHALL cover: DATA_W=8, cmd a=200 b=100 op=0 -> one sig_en_i pulse, rsp_data=9'h12C, status 00, captured 1 cycle after issue.
REQ-034 The bench SHALL cover: a=5 b=7 op=1 -> rsp_data=9'h1FE, status 00.
REQ-035 The bench SHALL cover: op=3 -> no sig_en_i pulse, status 10, rsp_data 0.
REQ-036 The bench SHALL cover: adder model never asserting sig_en_o, TIMEOUT=16 -> status 01 exactly 16 WAIT cycles after issue.
REQ-037 The bench SHALL cover: rsp_ready held 0 with 6 commands pushed -> cmd_ready low after 5 accepted; releasing rsp_ready -> 5 in-order responses.
REQ-038 The bench SHALL cover: sig_rst pulsed low during WAIT -> outputs 0 immediately, no response after release, FIFO empty.
